updown_mod_counter: RTL
=======================

# updown_mod_counter

Parametrised modulo up/down counter with enable, synchronous load, programmable step, and overflow/underflow pulses. Wrap-around is always present, and a saturating mode can be compiled in. It replaces fixed-width 3-bit up/down counters wherever a block needs a configurable range, such as decade counters, pointer counters or timeouts. It is a standalone leaf block driven by the system clock.

## Interface
- `WIDTH`, 8: counter width in bits; minimum 2.
- `MAX_VAL`, 2**WIDTH-1: highest count value, giving range 0..MAX_VAL. Must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `STEP_W`, 4: width of the `step` input.
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `en`  in  1  count enable.
- `up_down`  in  1  direction: 1 = up, 0 = down.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value captured on `load`.
- `step`  in  STEP_W  increment/decrement magnitude.
- `sat_mode`  in  1  1 = saturate, 0 = wrap. Present only with `UDC_SATURATE_EN`.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational: (`up_down` & `count`==MAX_VAL) | (!`up_down` & `count`==0).
- `ovf`  out  1  registered one-cycle overflow pulse.
- `unf`  out  1  registered one-cycle underflow pulse.

## Operation
- **Reset:** `rstn` low forces `count`=0, `ovf`=0, `unf`=0 immediately, with no clock edge needed. Reset mid-count discards the operation in flight.
- **Priority per rising edge:** `load` > `en` > hold.
- **Load:**
  - `count` ← min(`load_val`, MAX_VAL).
  - `ovf`/`unf` are 0 that cycle.
  - `en` is ignored while `load` is high.
- **Effective step:** s = min(`step`, MAX_VAL).
  - s = 0 with `en`=1 holds `count` and raises no flags.
  - `en`=0 holds and clears both flags.
- **Up:** compute sum = `count` + s in WIDTH+1 bits.
  - sum ≤ MAX_VAL: `count` ← sum.
  - Otherwise, wrap: `count` ← sum − (MAX_VAL+1); saturate: `count` ← MAX_VAL. `ovf`=1 in both cases.
- **Down:**
  - s ≤ `count`: `count` ← `count` − s.
  - Otherwise, wrap: `count` ← `count` + (MAX_VAL+1) − s; saturate: `count` ← 0. `unf`=1 in both cases.
- **Saturate at a limit:** a further step in the same direction keeps `count` at the limit and still pulses `ovf`/`unf`. This applies for every such request.
- **Direction change:** `up_down` may change on any cycle. The new direction applies at the next edge, and `tc` follows immediately.
- `ovf` and `unf` are never high together.

## Timing
- Count latency is one cycle: inputs sampled at edge N appear on `count` after edge N.
- `ovf`/`unf` assert in the same cycle that `count` takes the wrapped or saturated value. They last one cycle and stay high across consecutive cycles only if each cycle overflows or underflows again.
- `tc` is combinational from `count` and `up_down`, with no register stage.
- Reset assertion is asynchronous. Deassertion is synchronised externally; the first count edge follows rstn high.

## Configuration
- **`UDC_SATURATE_EN` defined:** the `sat_mode` port exists and is sampled every cycle. A mode change takes effect at the next edge.
- **Undefined:** no `sat_mode` port, no saturation logic; behaviour is wrap-only.

## Structure
- **Package `updown_cnt_pkg`** holds:
  - the `dir_e` enum (DIR_DOWN=0, DIR_UP=1);
  - the `ovf_kind_e` enum (NONE, OVF, UNF);
  - the parameter-check helper function, which flags MAX_VAL out of range at elaboration.
- **Sub-module `udc_next_val`** is combinational and computes the next count and flag kind from count, s, direction and mode.
- **Top level** holds the registers, load/enable priority, and `tc`.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9 and the macro defined unless stated.
- `count`=5, `en`=1; drop `rstn` between edges → `count`=0, `ovf`=`unf`=0 before the next edge; counting resumes from 0 after release.
- Up, step=1 from 8 → 9 with `tc`=1; next edge → 0 with `ovf`=1 for exactly one cycle, then 1 with `ovf`=0.
- Down, step=3, wrap, from 1 → 8 with `unf`=1; next edge → 5 with `unf`=0.
- `sat_mode`=1, up, step=4 from 7 → 9 with `ovf`=1; next edge → 9 with `ovf`=1 again. Switch to down → 5, flags 0.
- `load`=1, `load_val`=12, `en`=1 up, same edge → `count`=9 (clamped), `ovf`=0. `load_val`=3 → 3.
- `en`=1 with step=0 → hold, flags 0. `en`=0 with step=5 → hold. Step=15 up from 0 → clamped s=9, `count`=9, no `ovf`. Macro undefined: the same saturate stimulus wraps instead.

Source files
------------

// File: rtl/updown_cnt_pkg.sv
// Shared types and parameter checking for the modulo up/down counter.
package updown_cnt_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OVF  = 2'd1,
    UNF  = 2'd2
  } ovf_kind_e;

  // True when WIDTH and MAX_VAL describe a legal counter range.
  function automatic bit udc_params_ok(input int width, input longint max_val);
    longint lim;
    if (width < 2 || width > 62) begin
      return 1'b0;
    end else begin
      lim = (64'sd1 <<< width) - 64'sd1;
      return (max_val >= 64'sd1) && (max_val <= lim);
    end
  endfunction

endpackage

// File: rtl/udc_next_val.sv
// Combinational next-count and flag-kind computation for one counting step.
// Saturation support is compiled in only when UDC_SATURATE_EN is defined.
module udc_next_val
  import updown_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  dir_e             dir,
`ifdef UDC_SATURATE_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] next_val,
  output ovf_kind_e        kind
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_X = MAX_X + (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] wrap_up_s;
  logic [WIDTH:0] wrap_dn_s;

  assign sum_s     = {1'b0, count} + {1'b0, s};
  assign wrap_up_s = sum_s - MOD_X;
  // count < s here, so the borrowed result always lands inside 0..MAX_VAL.
  assign wrap_dn_s = {1'b0, count} + MOD_X - {1'b0, s};

  always_comb begin
    next_val = count;
    kind     = NONE;
    case (dir)
      DIR_UP: begin
        if (sum_s <= MAX_X) begin
          next_val = sum_s[WIDTH-1:0];
        end else begin
          kind = OVF;
`ifdef UDC_SATURATE_EN
          if (sat_mode) begin
            next_val = MAX_W;
          end else begin
            next_val = wrap_up_s[WIDTH-1:0];
          end
`else
          next_val = wrap_up_s[WIDTH-1:0];
`endif
        end
      end
      DIR_DOWN: begin
        if (s <= count) begin
          next_val = count - s;
        end else begin
          kind = UNF;
`ifdef UDC_SATURATE_EN
          if (sat_mode) begin
            next_val = {WIDTH{1'b0}};
          end else begin
            next_val = wrap_dn_s[WIDTH-1:0];
          end
`else
          next_val = wrap_dn_s[WIDTH-1:0];
`endif
        end
      end
      default: begin
        next_val = count;
        kind     = NONE;
      end
    endcase
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo up/down counter with load, programmable step and overflow/underflow pulses.
// Define UDC_SATURATE_EN to add the sat_mode port and saturating behaviour.
module updown_mod_counter
  import updown_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              up_down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
`ifdef UDC_SATURATE_EN
  input  logic              sat_mode,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  if (!udc_params_ok(WIDTH, longint'(MAX_VAL))) begin : g_bad_params
    $error("updown_mod_counter: MAX_VAL out of range for WIDTH");
  end

  localparam int             EW    = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [EW-1:0]  MAX_E = EW'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [EW-1:0]    step_ext_s;
  logic [WIDTH-1:0] s_eff_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic [WIDTH-1:0] next_val_s;
  ovf_kind_e        kind_s;

  assign step_ext_s   = EW'(step);
  assign s_eff_s      = (step_ext_s > MAX_E) ? MAX_W : WIDTH'(step_ext_s);
  assign load_clamp_s = (load_val > MAX_W) ? MAX_W : load_val;

  udc_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count    (count_q),
    .s        (s_eff_s),
    .dir      (dir_e'(up_down)),
`ifdef UDC_SATURATE_EN
    .sat_mode (sat_mode),
`endif
    .next_val (next_val_s),
    .kind     (kind_s)
  );

  // Load beats enable; a disabled counter holds and drops both flags.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_clamp_s;
    end else if (en) begin
      count_d = next_val_s;
      ovf_d   = (kind_s == OVF);
      unf_d   = (kind_s == UNF);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign tc    = up_down ? (count_q == MAX_W) : (count_q == {WIDTH{1'b0}});

endmodule
